im_boot_loader: RTL and testbench

Byte-serial boot loader that sits directly upstream of the single-cycle CPU. It receives a framed program image over a valid/ready byte stream and assembles big-endian 32-bit words. It writes those words into the instruction memory through the IM write port and holds the CPU in reset until a complete, checksum-verified image is resident. After release it is idle until the next `rst`.

---
 rtl/im_boot_loader_if.sv | 19 +
 rtl/im_boot_loader.sv | 87 ++++++++
 tb/tb_im_boot_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/im_boot_loader_if.sv
// Byte-stream input plus IM write port and CPU-control outputs of the boot loader.
// master = stream source / IM / CPU side, slave = the loader itself.
interface im_boot_loader_if #(parameter int IM_AW = 6);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_wd;
  logic             cpu_rst;
  logic             done;
  logic             err;
  logic [IM_AW:0]   words_loaded;

  modport master (output rx_data, rx_valid,
                  input  rx_ready, im_we, im_addr, im_wd, cpu_rst, done, err, words_loaded);
  modport slave  (input  rx_data, rx_valid,
                  output rx_ready, im_we, im_addr, im_wd, cpu_rst, done, err, words_loaded);
endinterface

// File: rtl/im_boot_loader.sv
// Framed byte-serial image loader: header N, 4*N big-endian payload bytes, checksum.
// Writes words into IM and holds the CPU in reset until the checksum verifies.
module im_boot_loader #(
  parameter int IM_AW = 6
) (
  input logic clk,
  input logic rst,
  im_boot_loader_if.slave bus
);
  localparam int CAP = 1 << IM_AW;

  typedef enum logic [2:0] {HDR, DATA, CKSUM, RUN, ERR} state_t;

  state_t           state, state_nxt;
  logic [7:0]       sum, sum_nxt, n_q;
  logic [1:0]       bcnt;
  logic [23:0]      asm_q;
  logic [IM_AW:0]   wl;
  logic             acc, word_done, last_word, hdr_big;
  logic             we_q;
  logic [IM_AW-1:0] addr_q;
  logic [31:0]      wd_q;

  assign bus.rx_ready = (state == HDR) || (state == DATA) || (state == CKSUM);
  assign acc          = bus.rx_valid && bus.rx_ready;
  assign sum_nxt      = sum + bus.rx_data;
  assign hdr_big      = 32'(bus.rx_data) > 32'(CAP);
  assign last_word    = (32'(wl) + 32'd1) == 32'(n_q);

  assign bus.cpu_rst      = (state != RUN);
  assign bus.done         = (state == RUN);
  assign bus.err          = (state == ERR);
  assign bus.im_we        = we_q;
  assign bus.im_addr      = addr_q;
  assign bus.im_wd        = wd_q;
  assign bus.words_loaded = wl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    word_done = 1'b0;
    unique case (state)
      HDR: if (acc) begin
        if (bus.rx_data == 8'h00) state_nxt = CKSUM;
        else if (hdr_big)         state_nxt = ERR;
        else                      state_nxt = DATA;
      end
      DATA: if (acc && bcnt == 2'd3) begin
        word_done = 1'b1;
        if (last_word) state_nxt = CKSUM;
      end
      CKSUM: if (acc) state_nxt = (sum_nxt == 8'h00) ? RUN : ERR;
      default: ;
    endcase
  end

  // Only the first three bytes of a word are buffered; the fourth goes straight to im_wd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum    <= '0;
      n_q    <= '0;
      bcnt   <= '0;
      asm_q  <= '0;
      wl     <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      we_q <= word_done;
      if (acc) sum <= sum_nxt;
      if (acc && state == HDR) n_q <= bus.rx_data;
      if (acc && state == DATA) begin
        bcnt  <= bcnt + 2'd1;
        asm_q <= {asm_q[15:0], bus.rx_data};
      end
      if (word_done) begin
        addr_q <= wl[IM_AW-1:0];
        wd_q   <= {asm_q, bus.rx_data};
        wl     <= wl + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_im_boot_loader.sv
// Scoreboarded random-frame bench for im_boot_loader.
module tb_im_boot_loader;
  localparam int IM_AW = 6;
  localparam int CAP   = 1 << IM_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  im_boot_loader_if #(.IM_AW(IM_AW)) bus();
  im_boot_loader #(.IM_AW(IM_AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [IM_AW-1:0] addr;
    logic [31:0]      data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every IM write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %08h, expected no write", bus.im_addr, bus.im_wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.im_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(bus.im_wd), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd1);
    chk({tag, "_im_we"},    64'(bus.im_we), 64'd0);
    chk({tag, "_im_addr"},  64'(bus.im_addr), 64'd0);
    chk({tag, "_im_wd"},    64'(bus.im_wd), 64'd0);
    chk({tag, "_cpu_rst"},  64'(bus.cpu_rst), 64'd1);
    chk({tag, "_done"},     64'(bus.done), 64'd0);
    chk({tag, "_err"},      64'(bus.err), 64'd0);
    chk({tag, "_words"},    64'(bus.words_loaded), 64'd0);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Called and returns at posedge+1; the byte is accepted on the edge just before return.
  task automatic send_byte(input logic [7:0] b, input int gmax);
    int gap, n;
    gap = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got rx_ready %0b expected 1 within 20 cycles", bus.rx_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] n, input logic [31:0] w[$],
                            input logic [7:0] cdelta, input int gmax);
    logic [7:0] s, c;
    wr_t e;
    bit  good_hdr;
    s = n;
    for (int k = 0; k < int'(n) && k < w.size(); k++)
      s = s + w[k][31:24] + w[k][23:16] + w[k][15:8] + w[k][7:0];
    c = 8'(8'h00 - s) + cdelta;
    good_hdr = int'(n) <= CAP;
    if (good_hdr)
      for (int k = 0; k < int'(n); k++) begin
        e.addr = IM_AW'(k);
        e.data = w[k];
        exp_q.push_back(e);
      end
    send_byte(n, gmax);
    if (!good_hdr) begin
      chk("bad_hdr_err", 64'(bus.err), 64'd1);
      chk("bad_hdr_ready", 64'(bus.rx_ready), 64'd0);
      chk("bad_hdr_cpu_rst", 64'(bus.cpu_rst), 64'd1);
      bus.rx_valid = 1'b0;
      return;
    end
    for (int k = 0; k < int'(n); k++)
      for (int b = 3; b >= 0; b--)
        send_byte(w[k][8*b +: 8], gmax);
    chk("pre_c_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    send_byte(c, gmax);
    chk("post_c_done",    64'(bus.done), 64'(cdelta == 8'h00));
    chk("post_c_err",     64'(bus.err), 64'(cdelta != 8'h00));
    chk("post_c_cpu_rst", 64'(bus.cpu_rst), 64'(cdelta != 8'h00));
    bus.rx_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    chk("words_loaded", 64'(bus.words_loaded), 64'(n));
    chk("final_ready", 64'(bus.rx_ready), 64'd0);
  endtask

  // Offer bytes in a terminal state: nothing may change.
  task automatic offer_ignored(input logic [IM_AW:0] wl, input logic dn, input logic er);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (4) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b0;
    chk("hold_words", 64'(bus.words_loaded), 64'(wl));
    chk("hold_done", 64'(bus.done), 64'(dn));
    chk("hold_err", 64'(bus.err), 64'(er));
    chk("hold_ready", 64'(bus.rx_ready), 64'd0);
  endtask

  logic [31:0] img[$];
  logic [31:0] none[$];
  logic [31:0] ff64[$];
  logic [31:0] rimg[$];
  logic [7:0]  rn, rd;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    img = '{32'h20080005, 32'h01084020};
    for (int k = 0; k < CAP; k++) ff64.push_back(32'hFFFF_FFFF);
    #2 check_reset_vals("rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    send_frame(8'd2, img, 8'd0, 0);
    offer_ignored(7'd2, 1'b1, 1'b0);

    do_reset();
    send_frame(8'd2, img, 8'd1, 0);
    offer_ignored(7'd2, 1'b0, 1'b1);

    do_reset();
    send_frame(8'h41, none, 8'd0, 0);
    offer_ignored(7'd0, 1'b0, 1'b1);

    do_reset();
    send_frame(8'h40, ff64, 8'd0, 0);

    do_reset();
    send_frame(8'h00, none, 8'd0, 0);
    do_reset();
    send_frame(8'h00, none, 8'd1, 0);

    do_reset();
    send_frame(8'd2, img, 8'd0, 5);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      rn = 8'($urandom_range(CAP, 1));
      rimg.delete();
      for (int k = 0; k < int'(rn); k++) rimg.push_back($urandom);
      rd = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
      send_frame(rn, rimg, rd, int'($urandom_range(3, 0)));
    end

    // Async reset after byte 2 of word 1; only word 0 is ever written.
    do_reset();
    mon_e.addr = '0;
    mon_e.data = 32'hA1B2C3D4;
    exp_q.push_back(mon_e);
    send_byte(8'd3, 0);
    send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    #2 rst = 1'b1;
    #1 check_reset_vals("abort");
    chk("abort_drained", 64'(exp_q.size()), 64'd0);
    bus.rx_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    send_frame(8'd2, img, 8'd0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
